decode_issue_queue: RTL

//   Buffered decode stage for the MIPS core. Accepts fetched {pc, instr} on a

---
 rtl/decode_issue_queue_pkg.sv | 109 ++++++++++
 rtl/decode_issue_queue_fifo.sv | 52 +++++
 rtl/decode_issue_queue.sv | 139 +++++++++++++
 3 files changed

// File: rtl/decode_issue_queue_pkg.sv
// Shared decode constants for the MIPS decode/issue queue: opcodes, functs,
// ALU op codes (EXE_*_OP) and the CP0 class encoding.
package decode_issue_queue_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
    localparam logic [7:0] EXE_LB_OP    = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP   = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP    = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP   = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP    = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP    = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP    = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP    = 8'b11101011;
    localparam logic [7:0] EXE_MFC0_OP  = 8'b01011101;
    localparam logic [7:0] EXE_MTC0_OP  = 8'b01100000;

    typedef enum logic [1:0] {
        CP0_NONE = 2'b00,
        CP0_MFC0 = 2'b01,
        CP0_MTC0 = 2'b10
    } cp0_class_t;

    typedef struct packed {
        logic [7:0] aluop;
        logic       ri;
        cp0_class_t cp0;
    } dec_t;

endpackage

// File: rtl/decode_issue_queue_fifo.sv
// Synchronous FIFO with occupancy count; flush clears pointers and count.
// Head entry is read straight from the storage registers (no read latency).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !srst)
            mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/decode_issue_queue.sv
// Buffered MIPS decode stage: decodes on entry, queues {pc, instr, aluop,
// ri, cp0} until EX pops the head. flush discards everything.
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int ALUOP_W = 8,
    parameter int CP0_EN  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_pc,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [31:0]            out_instr,
    output logic [ALUOP_W-1:0]     out_aluop,
    output logic                   out_ri,
    output logic [1:0]             out_cp0,
    output logic [$clog2(DEPTH):0] count
);
    localparam int W = ADDR_W + 32 + ALUOP_W + 3;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.aluop = EXE_NOP_OP;
        d.ri    = 1'b0;
        d.cp0   = CP0_NONE;
        case (instr[31:26])
            OP_SPECIAL: begin
                case (instr[5:0])
                    FN_SLL:   d.aluop = EXE_SLL_OP;
                    FN_SRL:   d.aluop = EXE_SRL_OP;
                    FN_SRA:   d.aluop = EXE_SRA_OP;
                    FN_SLLV:  d.aluop = EXE_SLLV_OP;
                    FN_SRLV:  d.aluop = EXE_SRLV_OP;
                    FN_SRAV:  d.aluop = EXE_SRAV_OP;
                    FN_JR, FN_JALR: d.aluop = EXE_NOP_OP;
                    FN_MFHI:  d.aluop = EXE_MFHI_OP;
                    FN_MTHI:  d.aluop = EXE_MTHI_OP;
                    FN_MFLO:  d.aluop = EXE_MFLO_OP;
                    FN_MTLO:  d.aluop = EXE_MTLO_OP;
                    FN_MULT:  d.aluop = EXE_MULT_OP;
                    FN_MULTU: d.aluop = EXE_MULTU_OP;
                    FN_DIV:   d.aluop = EXE_DIV_OP;
                    FN_DIVU:  d.aluop = EXE_DIVU_OP;
                    FN_ADD:   d.aluop = EXE_ADD_OP;
                    FN_ADDU:  d.aluop = EXE_ADDU_OP;
                    FN_SUB:   d.aluop = EXE_SUB_OP;
                    FN_SUBU:  d.aluop = EXE_SUBU_OP;
                    FN_AND:   d.aluop = EXE_AND_OP;
                    FN_OR:    d.aluop = EXE_OR_OP;
                    FN_XOR:   d.aluop = EXE_XOR_OP;
                    FN_NOR:   d.aluop = EXE_NOR_OP;
                    FN_SLT:   d.aluop = EXE_SLT_OP;
                    FN_SLTU:  d.aluop = EXE_SLTU_OP;
                    default:  d.ri = 1'b1;
                endcase
            end
            OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                d.aluop = EXE_NOP_OP;
            OP_ADDI:  d.aluop = EXE_ADDI_OP;
            OP_ADDIU: d.aluop = EXE_ADDIU_OP;
            OP_SLTI:  d.aluop = EXE_SLT_OP;
            OP_SLTIU: d.aluop = EXE_SLTU_OP;
            OP_ANDI:  d.aluop = EXE_AND_OP;
            OP_ORI:   d.aluop = EXE_OR_OP;
            OP_XORI:  d.aluop = EXE_XOR_OP;
            OP_LUI:   d.aluop = EXE_LUI_OP;
            OP_LB:    d.aluop = EXE_LB_OP;
            OP_LH:    d.aluop = EXE_LH_OP;
            OP_LW:    d.aluop = EXE_LW_OP;
            OP_LBU:   d.aluop = EXE_LBU_OP;
            OP_LHU:   d.aluop = EXE_LHU_OP;
            OP_SB:    d.aluop = EXE_SB_OP;
            OP_SH:    d.aluop = EXE_SH_OP;
            OP_SW:    d.aluop = EXE_SW_OP;
            OP_COP0: begin
                // Only the exact mfc0/mtc0 encodings (sel=0, zero low bits) are legal.
                if (CP0_EN != 0 && instr[25:21] == 5'b00000 && instr[10:0] == 11'd0) begin
                    d.aluop = EXE_MFC0_OP;
                    d.cp0   = CP0_MFC0;
                end else if (CP0_EN != 0 && instr[25:21] == 5'b00100 && instr[10:0] == 11'd0) begin
                    d.aluop = EXE_MTC0_OP;
                    d.cp0   = CP0_MTC0;
                end else begin
                    d.ri = 1'b1;
                end
            end
            default: d.ri = 1'b1;
        endcase
        return d;
    endfunction

    dec_t          in_dec;
    logic [W-1:0]  wr_entry;
    logic [W-1:0]  rd_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign in_dec    = decode(in_instr);
    assign wr_entry  = {in_pc, in_instr, ALUOP_W'(in_dec.aluop), in_dec.ri, in_dec.cp0};

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Storage is not reset, so stale head contents are masked when empty.
    assign out_pc    = out_valid ? rd_entry[W-1 -: ADDR_W]         : '0;
    assign out_instr = out_valid ? rd_entry[3+ALUOP_W +: 32]       : '0;
    assign out_aluop = out_valid ? rd_entry[3 +: ALUOP_W]          : '0;
    assign out_ri    = out_valid ? rd_entry[2]                     : 1'b0;
    assign out_cp0   = out_valid ? rd_entry[1:0]                   : 2'b00;

endmodule
